// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if
// Groups the request, ALU and response channels of the ALU request arbiter.
//   req0_* / req1_* : per-requester valid/ready with operands a, b and opcode op
//   alu_*           : operands and opcode driven to the shared registered ALU, result back
//   rsp_*           : valid/ready response carrying requester id, data and divide-by-zero flag
// The slave modport is the arbiter's view; the master modport is the view of the
// surrounding environment (requesters, ALU and response consumer).
interface alu_req_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [2:0] req0_op;

  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [2:0] req1_op;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic       rsp_dz;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_data, rsp_dz,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_data, rsp_dz,
    output rsp_ready
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
// Shares one registered ALU between two requesters. A round-robin grant in IDLE
// latches the winner's operands onto the ALU inputs, the arbiter waits ALU_LAT
// cycles for the result, then returns it (tagged with the requester id, with
// illegal divides forced to 8'hFF and flagged) over a valid/ready response.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : alu_req_arbiter_if.slave (request, ALU and response channels)
//   busy : high whenever the arbiter is not in IDLE
module alu_req_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_req_arbiter_if.slave      bus,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  state_t     state;
  state_t     state_next;
  logic       last;
  logic       cur_id;
  logic [2:0] cnt;
  logic       grant0;
  logic       grant1;
  logic       dz_now;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Round-robin grant and next-state logic. On a tie the requester that did
  // not win last time is granted; a lone requester always wins.
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      IDLE: begin
        grant0 = bus.req0_valid & (~bus.req1_valid | last);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last);
        if (grant0 | grant1) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 3'd0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign busy           = (state != IDLE);

  // Illegal divide detection on the operands currently held on the ALU inputs.
  assign dz_now = ((bus.alu_op == 3'b100) && (bus.alu_b == 4'd0)) ||
                  ((bus.alu_op == 3'b101) && (bus.alu_a == 4'd0));

  // Datapath: operand latch on accept, latency countdown, result capture and
  // response hold. The id is kept in cur_id until capture so rsp_id only
  // changes when a new response is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_a     <= 4'd0;
      bus.alu_b     <= 4'd0;
      bus.alu_op    <= 3'd0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= 8'd0;
      bus.rsp_dz    <= 1'b0;
      cnt           <= 3'd0;
      last          <= 1'b1;
      cur_id        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            bus.alu_a  <= bus.req0_a;
            bus.alu_b  <= bus.req0_b;
            bus.alu_op <= bus.req0_op;
            cur_id     <= 1'b0;
            last       <= 1'b0;
            cnt        <= LAT_INIT;
          end else if (grant1) begin
            bus.alu_a  <= bus.req1_a;
            bus.alu_b  <= bus.req1_b;
            bus.alu_op <= bus.req1_op;
            cur_id     <= 1'b1;
            last       <= 1'b1;
            cnt        <= LAT_INIT;
          end
        end
        EXEC: begin
          if (cnt == 3'd0) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= cur_id;
            bus.rsp_dz    <= dz_now;
            bus.rsp_data  <= dz_now ? 8'hFF : bus.alu_result;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
          end
        end
        default: begin
          bus.rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
